// File: rtl/forward_hazard_unit_pkg.sv
// Shared types for the forwarding/hazard unit: tracked-entry layout and select encoding.
// Entries are stored with a fixed-width destination field so every instance shares one type.
package forward_hazard_unit_pkg;

  localparam int RAW_MAX     = 8;
  localparam int SEL_REGFILE = 0;

  typedef struct packed {
    logic               valid;
    logic               write;
    logic               is_load;
    logic [RAW_MAX-1:0] dest;
  } entry_t;

  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/forward_hazard_unit_fwd_select.sv
// Youngest-producer matcher and operand mux for one ID-stage source.
// Purely combinational; zero-cycle latency, no backpressure of its own.
module fwd_select
  import forward_hazard_unit_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RAW      = 5,
  parameter int DEPTH    = 3,
  parameter int ZERO_REG = 1,
  parameter int SEL_W    = 2
) (
  input  logic                    uses,
  input  logic [RAW-1:0]          addr,
  input  entry_t [DEPTH-1:0]      entries,
  input  logic [DEPTH*DATA_W-1:0] stage_data,
  input  logic [DATA_W-1:0]       rf_data,
  output logic [SEL_W-1:0]        sel,
  output logic [DATA_W-1:0]       data,
  output logic                    sel_is_load
);

  logic addr_ok;

  always_comb begin
    sel         = SEL_W'(SEL_REGFILE);
    data        = rf_data;
    sel_is_load = 1'b0;
    addr_ok     = uses && !((ZERO_REG != 0) && (addr == '0));
    // Walk oldest to youngest so the youngest match is the one left standing.
    for (int k = DEPTH; k >= 1; k--) begin
      if (addr_ok && entries[k-1].valid && entries[k-1].write &&
          entries[k-1].dest == RAW_MAX'(addr)) begin
        sel         = SEL_W'(k);
        data        = stage_data[(k-1)*DATA_W +: DATA_W];
        sel_is_load = entries[k-1].is_load;
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Tracks in-flight writers over DEPTH stages, forwards both ID sources, raises load-use stall.
// Select/data/stall are combinational; a stall holds ID and lets older stages drain; Flush wins.
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter  int DATA_W      = 32,
  parameter  int RAW         = 5,
  parameter  int DEPTH       = 3,
  parameter  int LOAD_READY  = 2,
  parameter  int FLUSH_DEPTH = 2,
  parameter  int ZERO_REG    = 1,
  parameter  int CNT_W       = 16,
  localparam int SEL_W       = sel_width(DEPTH)
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    Id_Valid,
  input  logic [RAW-1:0]          Id_RsAddr,
  input  logic [RAW-1:0]          Id_RtAddr,
  input  logic                    Id_UsesRs,
  input  logic                    Id_UsesRt,
  input  logic [RAW-1:0]          Id_DestAddr,
  input  logic                    Id_DestWrite,
  input  logic                    Id_IsLoad,
  input  logic                    Flush,
  input  logic [DEPTH*DATA_W-1:0] Stage_Data,
  input  logic [DATA_W-1:0]       RegFile_RsData,
  input  logic [DATA_W-1:0]       RegFile_RtData,
  output logic [DATA_W-1:0]       Fwd_RsData,
  output logic [DATA_W-1:0]       Fwd_RtData,
  output logic [SEL_W-1:0]        Fwd_RsSel,
  output logic [SEL_W-1:0]        Fwd_RtSel,
  output logic                    Stall,
  output logic [DEPTH-1:0]        Pipe_Valid,
  output logic [CNT_W-1:0]        Stall_Count
);

  entry_t [DEPTH-1:0] pipe_q, pipe_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  entry_t             id_entry;
  logic               rs_is_load, rt_is_load;
  logic               hazard_rs, hazard_rt;
  logic               accept;

  fwd_select #(
    .DATA_W(DATA_W), .RAW(RAW), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)
  ) u_sel_rs (
    .uses        (Id_UsesRs),
    .addr        (Id_RsAddr),
    .entries     (pipe_q),
    .stage_data  (Stage_Data),
    .rf_data     (RegFile_RsData),
    .sel         (Fwd_RsSel),
    .data        (Fwd_RsData),
    .sel_is_load (rs_is_load)
  );

  fwd_select #(
    .DATA_W(DATA_W), .RAW(RAW), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)
  ) u_sel_rt (
    .uses        (Id_UsesRt),
    .addr        (Id_RtAddr),
    .entries     (pipe_q),
    .stage_data  (Stage_Data),
    .rf_data     (RegFile_RtData),
    .sel         (Fwd_RtSel),
    .data        (Fwd_RtData),
    .sel_is_load (rt_is_load)
  );

  // A load is only hazardous while it sits in a stage before its result appears.
  assign hazard_rs = (Fwd_RsSel != SEL_W'(SEL_REGFILE)) && rs_is_load &&
                     (Fwd_RsSel < SEL_W'(LOAD_READY));
  assign hazard_rt = (Fwd_RtSel != SEL_W'(SEL_REGFILE)) && rt_is_load &&
                     (Fwd_RtSel < SEL_W'(LOAD_READY));
  assign Stall     = Id_Valid && (hazard_rs || hazard_rt) && !Flush;
  assign accept    = Id_Valid && !Stall && !Flush;

  always_comb begin
    id_entry         = '0;
    id_entry.valid   = 1'b1;
    id_entry.write   = Id_DestWrite;
    id_entry.is_load = Id_IsLoad;
    id_entry.dest    = RAW_MAX'(Id_DestAddr);

    pipe_d = pipe_q;
    for (int k = 1; k < DEPTH; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
    pipe_d[0] = accept ? id_entry : '0;
    if (Flush) begin
      for (int k = 0; k < FLUSH_DEPTH; k++) begin
        pipe_d[k] = '0;
      end
    end

    stall_cnt_d = stall_cnt_q;
    if (Stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_comb begin
    Pipe_Valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      Pipe_Valid[k] = pipe_q[k].valid;
    end
  end

  assign Stall_Count = stall_cnt_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pipe_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      pipe_q      <= pipe_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: directed vector table, random run against a history model, reset mid-run.
module tb_forward_hazard_unit;

  localparam logic [31:0] S1 = 32'h10101010;
  localparam logic [31:0] S2 = 32'h20202020;
  localparam logic [31:0] RA = 32'h11111111;
  localparam logic [31:0] RB = 32'h22222222;

  logic        clk;
  logic        rst_n;
  logic        id_v, urs, urt, dw, ld, fl;
  logic [4:0]  rs, rt, dst;
  logic [31:0] st1, st2, st3, rfa, rfb;
  logic [95:0] stage_data;
  logic [31:0] fwd_rs, fwd_rt;
  logic [1:0]  sel_rs, sel_rt;
  logic        stall;
  logic [2:0]  pv;
  logic [15:0] cnt;

  int errors;
  int checks;

  assign stage_data = {st3, st2, st1};

  forward_hazard_unit dut (
    .Clk            (clk),
    .Reset_n        (rst_n),
    .Id_Valid       (id_v),
    .Id_RsAddr      (rs),
    .Id_RtAddr      (rt),
    .Id_UsesRs      (urs),
    .Id_UsesRt      (urt),
    .Id_DestAddr    (dst),
    .Id_DestWrite   (dw),
    .Id_IsLoad      (ld),
    .Flush          (fl),
    .Stage_Data     (stage_data),
    .RegFile_RsData (rfa),
    .RegFile_RtData (rfb),
    .Fwd_RsData     (fwd_rs),
    .Fwd_RtData     (fwd_rt),
    .Fwd_RsSel      (sel_rs),
    .Fwd_RtSel      (sel_rt),
    .Stall          (stall),
    .Pipe_Valid     (pv),
    .Stall_Count    (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [4:0] rs; logic urs; logic [4:0] rt; logic urt;
    logic [4:0] dst; logic dw; logic ld; logic fl;
    logic [31:0] sd1; logic [31:0] sd2; logic [31:0] rfa;
    logic [1:0] e_rs_sel; logic [1:0] e_rt_sel;
    logic [31:0] e_rs; logic [31:0] e_rt;
    logic e_stall; logic [2:0] e_pv; logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    logic valid; logic write; logic load; logic [4:0] dest;
  } rec_t;

  vec_t vecs[$];
  rec_t hist[$];

  function automatic vec_t mk(
    input logic v, input logic [4:0] a_rs, input logic a_urs, input logic [4:0] a_rt,
    input logic a_urt, input logic [4:0] a_dst, input logic a_dw, input logic a_ld,
    input logic a_fl, input logic [31:0] a_sd1, input logic [31:0] a_sd2,
    input logic [31:0] a_rfa, input logic [1:0] ers, input logic [1:0] ert,
    input logic [31:0] edrs, input logic [31:0] edrt, input logic est,
    input logic [2:0] epv, input logic [15:0] ecnt);
    vec_t r;
    r.v = v; r.rs = a_rs; r.urs = a_urs; r.rt = a_rt; r.urt = a_urt;
    r.dst = a_dst; r.dw = a_dw; r.ld = a_ld; r.fl = a_fl;
    r.sd1 = a_sd1; r.sd2 = a_sd2; r.rfa = a_rfa;
    r.e_rs_sel = ers; r.e_rt_sel = ert; r.e_rs = edrs; r.e_rt = edrt;
    r.e_stall = est; r.e_pv = epv; r.e_cnt = ecnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] a_rs, input logic a_urs,
                       input logic [4:0] a_rt, input logic a_urt, input logic [4:0] a_dst,
                       input logic a_dw, input logic a_ld, input logic a_fl);
    id_v = v; rs = a_rs; urs = a_urs; rt = a_rt; urt = a_urt;
    dst = a_dst; dw = a_dw; ld = a_ld; fl = a_fl;
  endtask

  // Reference: stage k holds whatever slot was issued k cycles ago, unless killed.
  function automatic int ref_sel(input logic uses, input logic [4:0] a);
    for (int k = 1; k <= 3; k++) begin
      if (uses && a != 5'd0 && hist[k-1].valid && hist[k-1].write && hist[k-1].dest == a)
        return k;
    end
    return 0;
  endfunction

  function automatic logic [31:0] stage_val(input int k);
    if (k == 1) return st1;
    if (k == 2) return st2;
    return st3;
  endfunction

  int          m_cnt, e_srs, e_srt;
  logic        e_st, hz_rs, hz_rt;
  logic [2:0]  e_pv;
  rec_t        nr;
  rec_t        bubble;

  initial begin
    errors = 0;
    checks = 0;
    bubble = '{1'b0, 1'b0, 1'b0, 5'd0};
    rst_n = 1'b0;
    drive(1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    st1 = S1; st2 = S2; st3 = 32'h33333333; rfa = RA; rfb = RB;
    #3;
    chk("reset pipe_valid", {29'd0, pv}, 32'd0);
    chk("reset count", {16'd0, cnt}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset rs_sel", {30'd0, sel_rs}, 32'd0);
    chk("reset rt_sel", {30'd0, sel_rt}, 32'd0);
    chk("reset rs_data", fwd_rs, RA);
    chk("reset rt_data", fwd_rt, RB);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- directed vector table ----------------
    vecs.push_back(mk(1, 0,0, 0,0, 3,1,0,0, S1,S2,RA, 0,0, RA,RB, 0,3'b000,0));
    vecs.push_back(mk(1, 3,1, 7,1, 0,0,0,0, 32'h00001234,S2,RA, 1,0, 32'h00001234,RB, 0,3'b001,0));
    vecs.push_back(mk(1, 3,1, 3,1, 5,1,0,0, S1,32'h0BAD0002,RA, 2,2, 32'h0BAD0002,32'h0BAD0002, 0,3'b011,0));
    vecs.push_back(mk(1, 0,0, 0,0, 5,1,0,0, S1,S2,RA, 0,0, RA,RB, 0,3'b111,0));
    vecs.push_back(mk(1, 5,0, 5,1, 0,0,0,0, 32'hAAAA0000,32'h5555FFFF,RA, 0,1, RA,32'hAAAA0000, 0,3'b111,0));
    vecs.push_back(mk(0, 0,0, 0,0, 0,0,0,0, S1,S2,RA, 0,0, RA,RB, 0,3'b111,0));
    vecs.push_back(mk(0, 0,0, 0,0, 0,0,0,0, S1,S2,RA, 0,0, RA,RB, 0,3'b110,0));
    vecs.push_back(mk(1, 0,0, 0,0, 4,1,1,0, S1,S2,RA, 0,0, RA,RB, 0,3'b100,0));
    vecs.push_back(mk(1, 4,1, 0,0, 6,1,0,0, 32'hDEAD0001,S2,RA, 1,0, 32'hDEAD0001,RB, 1,3'b001,0));
    vecs.push_back(mk(1, 4,1, 0,0, 6,1,0,0, S1,32'h4C4C4C4C,RA, 2,0, 32'h4C4C4C4C,RB, 0,3'b010,1));
    vecs.push_back(mk(1, 0,0, 0,0, 0,1,0,0, S1,S2,RA, 0,0, RA,RB, 0,3'b101,1));
    vecs.push_back(mk(1, 0,1, 6,1, 9,1,1,0, S1,32'h66666666,32'h0, 0,2, 32'h0,32'h66666666, 0,3'b011,1));
    vecs.push_back(mk(1, 9,1, 0,0, 10,1,0,1, 32'h99990000,S2,RA, 1,0, 32'h99990000,RB, 0,3'b111,1));
    vecs.push_back(mk(0, 9,1, 0,1, 0,0,0,0, S1,S2,RA, 0,0, RA,RB, 0,3'b100,1));

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].rs, vecs[i].urs, vecs[i].rt, vecs[i].urt,
            vecs[i].dst, vecs[i].dw, vecs[i].ld, vecs[i].fl);
      st1 = vecs[i].sd1; st2 = vecs[i].sd2; rfa = vecs[i].rfa;
      @(negedge clk);
      chk($sformatf("row%0d rs_sel", i), {30'd0, sel_rs}, {30'd0, vecs[i].e_rs_sel});
      chk($sformatf("row%0d rt_sel", i), {30'd0, sel_rt}, {30'd0, vecs[i].e_rt_sel});
      chk($sformatf("row%0d rs_data", i), fwd_rs, vecs[i].e_rs);
      chk($sformatf("row%0d rt_data", i), fwd_rt, vecs[i].e_rt);
      chk($sformatf("row%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
      chk($sformatf("row%0d pipe_valid", i), {29'd0, pv}, {29'd0, vecs[i].e_pv});
      chk($sformatf("row%0d count", i), {16'd0, cnt}, {16'd0, vecs[i].e_cnt});
      @(posedge clk); #1;
    end

    // ---------------- randomized run against history model ----------------
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    hist.delete();
    for (int k = 0; k < 3; k++) hist.push_back(bubble);
    m_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0);
      st1 = $urandom; st2 = $urandom; st3 = $urandom; rfa = $urandom; rfb = $urandom;
      e_srs = ref_sel(urs, rs);
      e_srt = ref_sel(urt, rt);
      hz_rs = (e_srs != 0) && hist[e_srs-1].load && (e_srs < 2);
      hz_rt = (e_srt != 0) && hist[e_srt-1].load && (e_srt < 2);
      e_st  = id_v && (hz_rs || hz_rt) && !fl;
      e_pv  = {hist[2].valid, hist[1].valid, hist[0].valid};
      @(negedge clk);
      chk($sformatf("rnd%0d rs_sel", c), {30'd0, sel_rs}, 32'(e_srs));
      chk($sformatf("rnd%0d rt_sel", c), {30'd0, sel_rt}, 32'(e_srt));
      chk($sformatf("rnd%0d rs_data", c), fwd_rs, (e_srs != 0) ? stage_val(e_srs) : rfa);
      chk($sformatf("rnd%0d rt_data", c), fwd_rt, (e_srt != 0) ? stage_val(e_srt) : rfb);
      chk($sformatf("rnd%0d stall", c), {31'd0, stall}, {31'd0, e_st});
      chk($sformatf("rnd%0d pipe_valid", c), {29'd0, pv}, {29'd0, e_pv});
      chk($sformatf("rnd%0d count", c), {16'd0, cnt}, 32'(m_cnt));
      @(posedge clk);
      nr = '{1'b1, dw, ld, dst};
      hist.push_front((id_v && !e_st && !fl) ? nr : bubble);
      void'(hist.pop_back());
      if (fl) begin
        hist[0] = bubble;
        hist[1] = bubble;
      end
      if (e_st && m_cnt < 65535) m_cnt++;
      #1;
    end

    // ---------------- reset in the middle of a busy pipe ----------------
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
      drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
    rfa = RA; rfb = RB;
    @(negedge clk);
    chk("busy pipe_valid", {29'd0, pv}, 32'd7);
    chk("busy count", {16'd0, cnt}, 32'd5);
    chk("busy stall", {31'd0, stall}, 32'd1);
    chk("busy rs_sel", {30'd0, sel_rs}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst pipe_valid", {29'd0, pv}, 32'd0);
    chk("midrst count", {16'd0, cnt}, 32'd0);
    chk("midrst stall", {31'd0, stall}, 32'd0);
    chk("midrst rs_sel", {30'd0, sel_rs}, 32'd0);
    chk("midrst rt_sel", {30'd0, sel_rt}, 32'd0);
    chk("midrst rs_data", fwd_rs, RA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/forward_hazard_unit.md
Name: forward_hazard_unit

Overview:
- Parametrised successor to the fixed two-source forwarding logic in the MIPS pipeline.
- Tracks in-flight register writers across DEPTH post-decode stages in a tag shift register.
- Selects the youngest matching producer for each of the two ID-stage sources.
- Raises a load-use stall when the producer's data is not yet valid; honours branch flush.

Parameters:
- DATA_W, 32, datapath width.
- RAW, 5, register address width.
- DEPTH, 3, tracked stages after ID (stage 1 = EX … stage DEPTH = WB); legal 1..7.
- LOAD_READY, 2, first stage index at which a load's result is valid on Stage_Data; 1..DEPTH.
- FLUSH_DEPTH, 2, number of youngest tracked entries killed by Flush; 0..DEPTH.
- ZERO_REG, 1, when 1, register 0 is never matched.
- CNT_W, 16, stall counter width.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Id_Valid  in  1  ID slot holds a real instruction.
- Id_RsAddr  in  RAW  source A address.
- Id_RtAddr  in  RAW  source B address.
- Id_UsesRs  in  1  instruction reads Rs.
- Id_UsesRt  in  1  instruction reads Rt.
- Id_DestAddr  in  RAW  destination register.
- Id_DestWrite  in  1  instruction writes Id_DestAddr.
- Id_IsLoad  in  1  instruction is a load.
- Flush  in  1  branch taken; kill younger instructions.
- Stage_Data  in  DEPTH*DATA_W  result of stage k on bits [k*DATA_W-1 -: DATA_W].
- RegFile_RsData  in  DATA_W  register file read A.
- RegFile_RtData  in  DATA_W  register file read B.
- Fwd_RsData  out  DATA_W  forwarded operand A.
- Fwd_RtData  out  DATA_W  forwarded operand B.
- Fwd_RsSel  out  SEL_W  0 = register file, k = stage k; SEL_W = clog2(DEPTH+1).
- Fwd_RtSel  out  SEL_W  same encoding for operand B.
- Stall  out  1  hold IF/ID, inject bubble into stage 1.
- Pipe_Valid  out  DEPTH  bit k-1 = stage k entry valid.
- Stall_Count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State: per stage k, entry {valid, write, is_load, dest}.
- Reset_n low (asynchronous): all entries invalid, Stall_Count = 0.
  - Combinational outputs then settle to: Stall = 0, both Sel = 0, Fwd data = register-file passthrough, Pipe_Valid = 0.
- Match for source S, stage k:
  - Uses_S && entry_k.valid && entry_k.write && entry_k.dest == Addr_S && !(ZERO_REG && Addr_S == 0).
  - Sel_S = smallest matching k (youngest wins), else 0.
  - Fwd_S_Data = Sel_S ? Stage_Data[k] : RegFile_S_Data.
  - Sel and data outputs are purely combinational from entries and ID inputs; zero-cycle latency.
- Hazard_S = Sel_S != 0 && entry_Sel.is_load && Sel_S < LOAD_READY.
- Stall = Id_Valid && (Hazard_Rs || Hazard_Rt) && !Flush.
- Rising-edge update:
  - Entries k >= 2 take entry k-1 unconditionally; older stages keep draining during a stall.
  - Entry 1 takes the ID instruction when Id_Valid && !Stall && !Flush; otherwise it becomes a bubble.
  - Flush: after the shift, entries 1..FLUSH_DEPTH become bubbles. Flush overrides Stall.
- Stall_Count increments on each cycle with Stall = 1 and holds at all-ones.
- A stall resolves by itself: the load advances one stage per cycle, so the stall lasts at most LOAD_READY-1 cycles.
- Rs and Rt are matched independently; both may select the same stage.

Decomposition:
- Shared package/header holds:
  - the entry field layout (valid, write, is_load, dest);
  - the SEL_W computation;
  - the select encoding constant SEL_REGFILE = 0.
- One sub-module, fwd_select: priority matcher plus data mux for one source. Instantiated twice (Rs, Rt).
- The tag shift register, stall logic and counter stay in the top module.

Test Plan (DEPTH=3, LOAD_READY=2, FLUSH_DEPTH=2):
- Back-to-back ALU dependence:
  - Stimulus: add writing r3 issued; next cycle consumer reads Rs = r3; Stage_Data[1] = 0x00001234.
  - Response: Fwd_RsSel = 1, Fwd_RsData = 0x00001234, Stall = 0.
- Youngest-wins priority:
  - Stimulus: r5 written by stage 1 (0xAAAA0000) and stage 2 (0x5555FFFF); consumer reads Rt = r5.
  - Response: Fwd_RtSel = 1, Fwd_RtData = 0xAAAA0000.
- Load-use stall:
  - Stimulus: lw r4 issued; next cycle consumer of r4.
  - Response: Stall = 1 for exactly one cycle; Pipe_Valid = 3'b010 on the following cycle; then Fwd_RsSel = 2 with the load data; Stall_Count = 1.
- Zero register:
  - Stimulus: producer writes r0; consumer reads r0; RegFile_RsData = 0.
  - Response: Fwd_RsSel = 0, Fwd_RsData = 0.
- Flush during stall:
  - Stimulus: load in stage 1, dependent in ID, Flush = 1.
  - Response: Stall = 0; next Pipe_Valid bits [1:0] = 0; Stall_Count unchanged.
- Reset mid-operation:
  - Stimulus: Reset_n low while Pipe_Valid = 3'b111 and Stall_Count = 5.
  - Response: immediately Pipe_Valid = 0, Stall_Count = 0, Stall = 0, both Sel = 0.
